// File: rtl/ras_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ras_ctrl                                                         |
// | Purpose : return-address-stack controller, TOS in a register, older        |
// |           entries spilled to / refilled from a circular dual-port RAM.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ras_ctrl #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 36,
   parameter int ADDR  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_addr_i,
   input  logic             pop_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] top_o,
   output logic             top_valid_o,
   output logic [ADDR:0]    depth_o,
   output logic             overflow_o,
   output logic             underflow_o,
   output logic             bram_ena_o,
   output logic             bram_wea_o,
   output logic [ADDR-1:0]  bram_addra_o,
   output logic [WIDTH-1:0] bram_dia_o,
   output logic             bram_enb_o,
   output logic             bram_web_o,
   output logic [ADDR-1:0]  bram_addrb_o,
   input  logic [WIDTH-1:0] bram_dob_i
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } state_t;

   localparam logic [ADDR:0]   c_depth   = (ADDR+1)'(DEPTH);
   localparam logic [ADDR:0]   c_cnt_one = (ADDR+1)'(1);
   localparam logic [ADDR-1:0] c_bp_one  = ADDR'(1);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_tos, w_tos_nxt;
   logic             r_tos_vld, w_tos_vld_nxt;
   logic [ADDR-1:0]  r_bp, w_bp_nxt;
   logic [ADDR:0]    r_cnt, w_cnt_nxt;
   logic             r_ovf, w_ovf_nxt;
   logic             r_udf, w_udf_nxt;

   logic w_idle, w_push_only, w_pop_only, w_spill, w_fill;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_push_only = w_idle & ~flush_i & push_i & ~pop_i;
   assign w_pop_only  = w_idle & ~flush_i & pop_i & ~push_i;
   assign w_spill     = w_push_only & r_tos_vld;
   assign w_fill      = w_pop_only & r_tos_vld & (r_cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_tos     <= '0;
         r_tos_vld <= 1'b0;
         r_bp      <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_udf     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tos     <= w_tos_nxt;
         r_tos_vld <= w_tos_vld_nxt;
         r_bp      <= w_bp_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ovf     <= w_ovf_nxt;
         r_udf     <= w_udf_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_tos_nxt     = r_tos;
      w_tos_vld_nxt = r_tos_vld;
      w_bp_nxt      = r_bp;
      w_cnt_nxt     = r_cnt;
      w_ovf_nxt     = 1'b0;
      w_udf_nxt     = 1'b0;
      if (flush_i) begin
         w_state_nxt   = ST_IDLE;
         w_tos_vld_nxt = 1'b0;
         w_bp_nxt      = '0;
         w_cnt_nxt     = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (push_i && pop_i) begin
                  w_tos_nxt     = push_addr_i;
                  w_tos_vld_nxt = 1'b1;
               end else if (push_i) begin
                  // A full RAM keeps its count; the spill lands on the oldest slot.
                  if (r_tos_vld) begin
                     w_bp_nxt = r_bp + c_bp_one;
                     if (r_cnt == c_depth) w_ovf_nxt = 1'b1;
                     else                  w_cnt_nxt = r_cnt + c_cnt_one;
                  end
                  w_tos_nxt     = push_addr_i;
                  w_tos_vld_nxt = 1'b1;
               end else if (pop_i) begin
                  if (!r_tos_vld) begin
                     w_udf_nxt = 1'b1;
                  end else if (r_cnt == '0) begin
                     w_tos_vld_nxt = 1'b0;
                  end else begin
                     w_bp_nxt    = r_bp - c_bp_one;
                     w_cnt_nxt   = r_cnt - c_cnt_one;
                     w_state_nxt = ST_REFILL;
                  end
               end
            end
            ST_REFILL: begin
               w_tos_nxt   = bram_dob_i;
               w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign ready_o      = w_idle;
   assign top_o        = r_tos;
   assign top_valid_o  = r_tos_vld & w_idle;
   assign depth_o      = r_cnt + (ADDR+1)'(r_tos_vld);
   assign overflow_o   = r_ovf;
   assign underflow_o  = r_udf;

   assign bram_ena_o   = w_spill;
   assign bram_wea_o   = w_spill;
   assign bram_addra_o = r_bp;
   assign bram_dia_o   = r_tos;
   assign bram_enb_o   = w_fill;
   assign bram_web_o   = 1'b0;
   assign bram_addrb_o = r_bp - c_bp_one;

endmodule
`default_nettype wire

// File: tb/tb_ras_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ras_ctrl                                                      |
// | Purpose : bench for ras_ctrl with a queue-based stack model and a BRAM.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ras_ctrl;
   localparam int DEPTH = 4;
   localparam int WIDTH = 36;
   localparam int ADDR  = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0, push = 1'b0, pop = 1'b0;
   logic [WIDTH-1:0] addr = '0;
   logic             ready, top_valid, overflow, underflow;
   logic [WIDTH-1:0] top, dia;
   logic [ADDR:0]    depth;
   logic             ena, wea, enb, web;
   logic [ADDR-1:0]  addra, addrb;
   logic [WIDTH-1:0] dob = '0;
   logic [WIDTH-1:0] mem [DEPTH];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ras_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR(ADDR)) dut (
      .clk(clk), .rst(rst), .flush_i(flush), .push_i(push), .push_addr_i(addr),
      .pop_i(pop), .ready_o(ready), .top_o(top), .top_valid_o(top_valid),
      .depth_o(depth), .overflow_o(overflow), .underflow_o(underflow),
      .bram_ena_o(ena), .bram_wea_o(wea), .bram_addra_o(addra), .bram_dia_o(dia),
      .bram_enb_o(enb), .bram_web_o(web), .bram_addrb_o(addrb), .bram_dob_i(dob)
   );

   always @(posedge clk) begin
      if (ena && wea) mem[addra] <= dia;
      if (enb) dob <= mem[addrb];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: the stack as a queue (bottom at front), at most DEPTH+1 entries
   logic [WIDTH-1:0] stk[$];
   bit               busy, ov_e, un_e;
   int               bp_m;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stk.delete(); busy = 0; ov_e = 0; un_e = 0; bp_m = 0;
      end else begin
         ov_e = 0; un_e = 0;
         if (flush) begin
            stk.delete(); busy = 0; bp_m = 0;
         end else if (busy) begin
            busy = 0;
         end else if (push && pop) begin
            if (stk.size() == 0) stk.push_back(addr);
            else stk[stk.size()-1] = addr;
         end else if (push) begin
            if (stk.size() > 0) bp_m = (bp_m + 1) % DEPTH;
            if (stk.size() == DEPTH + 1) begin
               void'(stk.pop_front());
               ov_e = 1;
            end
            stk.push_back(addr);
         end else if (pop) begin
            if (stk.size() == 0) un_e = 1;
            else begin
               void'(stk.pop_back());
               if (stk.size() >= 1) begin
                  busy = 1;
                  bp_m = (bp_m + DEPTH - 1) % DEPTH;
               end
            end
         end
      end
   end

   int   e_sz;
   logic e_idle, e_ena, e_enb;

   always @(negedge clk) begin
      e_sz   = stk.size();
      e_idle = !busy;
      e_ena  = e_idle && !flush && push && !pop && (e_sz > 0);
      e_enb  = e_idle && !flush && pop && !push && (e_sz >= 2);
      chk("ready", ready, e_idle);
      chk("depth", depth, e_sz);
      chk("top_valid", top_valid, e_idle && (e_sz > 0));
      if (e_idle && e_sz > 0) chk("top", top, stk[e_sz-1]);
      chk("overflow", overflow, ov_e);
      chk("underflow", underflow, un_e);
      chk("ena", ena, e_ena);
      chk("wea", wea, e_ena);
      if (e_ena) begin
         chk("addra", addra, bp_m);
         chk("dia", dia, stk[e_sz-1]);
      end
      chk("enb", enb, e_enb);
      if (e_enb) chk("addrb", addrb, (bp_m + DEPTH - 1) % DEPTH);
      chk("web", web, 0);
   end

   task automatic drive(input logic pu, input logic po, input logic fl, input logic [WIDTH-1:0] a);
      push = pu; pop = po; flush = fl; addr = a;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   int n_ov;
   int ov_at;
   int r;

   initial begin
      drive(0, 0, 0, '0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", ready, 1);
      chk("rst_valid", top_valid, 0);
      chk("rst_depth", depth, 0);

      // push 1,2,3 with spills of 1@0 and 2@1
      drive(1, 0, 0, 36'h1); tick();
      drive(1, 0, 0, 36'h2); #1;
      chk("t1_ena0", ena, 1); chk("t1_addra0", addra, 0); chk("t1_dia0", dia, 36'h1);
      tick();
      drive(1, 0, 0, 36'h3); #1;
      chk("t1_ena1", ena, 1); chk("t1_addra1", addra, 1); chk("t1_dia1", dia, 36'h2);
      tick();
      drive(0, 0, 0, '0);
      chk("t1_top", top, 36'h3); chk("t1_depth", depth, 3);

      // pop with refill from RAM
      drive(0, 1, 0, '0); #1;
      chk("t2_enb", enb, 1); chk("t2_addrb", addrb, 1);
      tick();
      drive(0, 0, 0, '0);
      chk("t2_busy_ready", ready, 0); chk("t2_busy_valid", top_valid, 0);
      tick();
      chk("t2_top", top, 36'h2); chk("t2_depth", depth, 2); chk("t2_valid", top_valid, 1);

      // TOS replace
      drive(1, 0, 0, 36'h7); tick();
      drive(1, 1, 0, 36'h9); #1;
      chk("t4_ena", ena, 0); chk("t4_enb", enb, 0);
      tick();
      drive(0, 0, 0, '0);
      chk("t4_top", top, 36'h9); chk("t4_depth", depth, 3);

      // push during REFILL ignored; reset during REFILL
      drive(0, 1, 0, '0); tick();
      drive(1, 0, 0, 36'hAA); #1;
      chk("t5_ready", ready, 0);
      tick();
      drive(0, 0, 0, '0);
      chk("t5_top", top, 36'h2); chk("t5_depth", depth, 2);
      drive(0, 1, 0, '0); tick();
      drive(0, 0, 0, '0);
      rst = 1'b1; #1;
      chk("t5_rst_valid", top_valid, 0); chk("t5_rst_depth", depth, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("t5_post_valid", top_valid, 0); chk("t5_post_depth", depth, 0);

      // flush beats push
      for (int i = 1; i <= 3; i++) begin drive(1, 0, 0, WIDTH'(i)); tick(); end
      chk("t6_depth3", depth, 3);
      drive(1, 0, 1, 36'h5); tick();
      drive(0, 0, 0, '0);
      chk("t6_depth", depth, 0); chk("t6_valid", top_valid, 0);

      // wraparound overflow, drain, underflow
      n_ov = 0; ov_at = 0;
      for (int i = 1; i <= 6; i++) begin
         drive(1, 0, 0, WIDTH'(i));
         if (i == 6) begin
            #1 chk("t3_addra", addra, 0); chk("t3_dia", dia, 36'h5);
         end
         tick();
         if (overflow) begin n_ov++; ov_at = i; end
      end
      drive(0, 0, 0, '0);
      chk("t3_ov_count", n_ov, 1); chk("t3_ov_at", ov_at, 6);
      for (int v = 6; v >= 2; v--) begin
         chk("t3_pop_top", top, WIDTH'(v));
         drive(0, 1, 0, '0); tick();
         drive(0, 0, 0, '0);
         if (!ready) tick();
      end
      chk("t3_empty", depth, 0);
      drive(0, 1, 0, '0); tick();
      drive(0, 0, 0, '0);
      chk("t3_udf", underflow, 1);
      tick();
      chk("t3_udf_clear", underflow, 0);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 199);
         rst = (r == 0);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (r < 6),
               WIDTH'({$urandom, $urandom}));
         tick();
      end
      rst = 1'b0;
      drive(0, 0, 0, '0);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
